// File: rtl/fft4_frame_ctrl_if.sv
// Stream, fft4-operand and status bundle around fft4_frame_ctrl.
// master = the controller side, slave = source/sink/fft4 side.
interface fft4_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   localparam int OW = DATA_WIDTH + 2;

   logic                         flush;
   logic                         clr_err;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_real;
   logic signed [DATA_WIDTH-1:0] in_imag;
   logic                         fft_en;
   logic signed [DATA_WIDTH-1:0] fft_in0_real, fft_in0_imag, fft_in1_real, fft_in1_imag;
   logic signed [DATA_WIDTH-1:0] fft_in2_real, fft_in2_imag, fft_in3_real, fft_in3_imag;
   logic signed [OW-1:0]         fft_out0_real, fft_out0_imag, fft_out1_real, fft_out1_imag;
   logic signed [OW-1:0]         fft_out2_real, fft_out2_imag, fft_out3_real, fft_out3_imag;
   logic                         fft_yout_valid;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [OW-1:0]         out_real;
   logic signed [OW-1:0]         out_imag;
   logic [1:0]                   out_idx;
   logic                         out_last;
   logic [CNT_WIDTH-1:0]         frame_cnt;
   logic                         err;

   modport master (
      input  flush, clr_err, in_valid, in_real, in_imag,
      input  fft_out0_real, fft_out0_imag, fft_out1_real, fft_out1_imag,
      input  fft_out2_real, fft_out2_imag, fft_out3_real, fft_out3_imag,
      input  fft_yout_valid, out_ready,
      output in_ready, fft_en,
      output fft_in0_real, fft_in0_imag, fft_in1_real, fft_in1_imag,
      output fft_in2_real, fft_in2_imag, fft_in3_real, fft_in3_imag,
      output out_valid, out_real, out_imag, out_idx, out_last, frame_cnt, err
   );

   modport slave (
      output flush, clr_err, in_valid, in_real, in_imag,
      output fft_out0_real, fft_out0_imag, fft_out1_real, fft_out1_imag,
      output fft_out2_real, fft_out2_imag, fft_out3_real, fft_out3_imag,
      output fft_yout_valid, out_ready,
      input  in_ready, fft_en,
      input  fft_in0_real, fft_in0_imag, fft_in1_real, fft_in1_imag,
      input  fft_in2_real, fft_in2_imag, fft_in3_real, fft_in3_imag,
      input  out_valid, out_real, out_imag, out_idx, out_last, frame_cnt, err
   );
endinterface

// File: rtl/fft4_frame_ctrl.sv
// Frames a sample stream into 4-point fft4 launches and drains bins 0..3; launch 1 cycle after 4th
// accept, first bin 1 cycle after yout_valid; input stalls (HOLD) while the previous frame is undrained.
module fft4_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 64,
   parameter int CNT_WIDTH  = 16
) (
   input logic               clk,
   input logic               rst,
   fft4_frame_ctrl_if.master bus
);
   localparam int OW = DATA_WIDTH + 2;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {FILL, HOLD, LAUNCH, WAIT} state_t;

   state_t                       state, state_d;
   logic [1:0]                   cnt;
   logic [TW-1:0]                tcnt;
   logic signed [DATA_WIDTH-1:0] ibuf_re [4];
   logic signed [DATA_WIDTH-1:0] ibuf_im [4];
   logic signed [OW-1:0]         obuf_re [4];
   logic signed [OW-1:0]         obuf_im [4];
   logic                         obuf_full;
   logic [1:0]                   out_idx;
   logic [CNT_WIDTH-1:0]         frame_cnt;
   logic                         err;
   logic                         in_ready, fft_en, accept, capture, timeout;
   logic                         drain, drain_last, obuf_free;

   assign in_ready   = (state == FILL);
   assign fft_en     = (state == LAUNCH);
   assign accept     = bus.in_valid && in_ready && !bus.flush;
   assign drain      = obuf_full && bus.out_ready;
   assign drain_last = drain && (out_idx == 2'd3);
   // obuf counts as free when its last beat leaves this cycle, so a full frame can launch immediately
   assign obuf_free  = !obuf_full || drain_last;

   always_comb begin
      state_d = state;
      capture = 1'b0;
      timeout = 1'b0;
      case (state)
         FILL: begin
            if (accept && cnt == 2'd3)
               state_d = obuf_free ? LAUNCH : HOLD;
         end
         HOLD: begin
            if (obuf_free)
               state_d = LAUNCH;
         end
         LAUNCH: begin
            if (bus.fft_yout_valid) begin
               capture = 1'b1;
               state_d = FILL;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus.fft_yout_valid) begin
               capture = 1'b1;
               state_d = FILL;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
      if (bus.flush) begin
         state_d = FILL;
         capture = 1'b0;
         timeout = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         cnt       <= 2'd0;
         tcnt      <= '0;
         obuf_full <= 1'b0;
         out_idx   <= 2'd0;
         frame_cnt <= '0;
         err       <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            ibuf_re[k] <= '0;
            ibuf_im[k] <= '0;
            obuf_re[k] <= '0;
            obuf_im[k] <= '0;
         end
      end else begin
         state <= state_d;

         if (state == LAUNCH)
            tcnt <= '0;
         else if (state == WAIT)
            tcnt <= tcnt + TW'(1);

         if (bus.flush) begin
            cnt <= 2'd0;
         end else if (accept) begin
            ibuf_re[cnt] <= bus.in_real;
            ibuf_im[cnt] <= bus.in_imag;
            cnt          <= cnt + 2'd1;
         end else if (capture || timeout) begin
            cnt <= 2'd0;
         end

         if (capture) begin
            obuf_re[0] <= bus.fft_out0_real;
            obuf_im[0] <= bus.fft_out0_imag;
            obuf_re[1] <= bus.fft_out1_real;
            obuf_im[1] <= bus.fft_out1_imag;
            obuf_re[2] <= bus.fft_out2_real;
            obuf_im[2] <= bus.fft_out2_imag;
            obuf_re[3] <= bus.fft_out3_real;
            obuf_im[3] <= bus.fft_out3_imag;
         end

         // capture and drain never overlap: launch only happens once obuf is free
         if (bus.flush) begin
            obuf_full <= 1'b0;
            out_idx   <= 2'd0;
         end else if (capture) begin
            obuf_full <= 1'b1;
         end else if (drain) begin
            if (out_idx == 2'd3) begin
               obuf_full <= 1'b0;
               out_idx   <= 2'd0;
               frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end else begin
               out_idx <= out_idx + 2'd1;
            end
         end

         if (timeout)
            err <= 1'b1;
         else if (bus.clr_err)
            err <= 1'b0;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.fft_en       = fft_en;
   assign bus.fft_in0_real = ibuf_re[0];
   assign bus.fft_in0_imag = ibuf_im[0];
   assign bus.fft_in1_real = ibuf_re[1];
   assign bus.fft_in1_imag = ibuf_im[1];
   assign bus.fft_in2_real = ibuf_re[2];
   assign bus.fft_in2_imag = ibuf_im[2];
   assign bus.fft_in3_real = ibuf_re[3];
   assign bus.fft_in3_imag = ibuf_im[3];
   assign bus.out_valid    = obuf_full;
   assign bus.out_real     = obuf_re[out_idx];
   assign bus.out_imag     = obuf_im[out_idx];
   assign bus.out_idx      = out_idx;
   assign bus.out_last     = (out_idx == 2'd3);
   assign bus.frame_cnt    = frame_cnt;
   assign bus.err          = err;
endmodule
